// File: rtl/result_uart_tx.sv
// Walks the result RAM from address 0 after a filter run and sends each word
// over an 8N1 UART line, LSB first, with a fixed idle gap between frames.
module result_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int data_bits    = 8,
    parameter int addr_bits    = 8,
    parameter int NUM_WORDS    = 255,
    parameter int RD_LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [addr_bits-1:0] rd_addr,
    input  logic [data_bits-1:0] rd_data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (data_bits > 1) ? $clog2(data_bits) : 1;
    localparam int WAIT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam int WORD_W = addr_bits + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_bits - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [BAUD_W-1:0]     baud_r, baud_s;
    logic [BIT_W-1:0]      bit_r, bit_s;
    logic [WAIT_W-1:0]     wait_r, wait_s;
    logic [WORD_W-1:0]     word_r, word_s;
    logic [data_bits-1:0]  shift_r, shift_s;
    logic [addr_bits-1:0]  addr_r, addr_s;
    logic                  tx_r, tx_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;

    // State and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            baud_r  <= '0;
            bit_r   <= '0;
            wait_r  <= '0;
            word_r  <= '0;
            shift_r <= '0;
            addr_r  <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            wait_r  <= wait_s;
            word_r  <= word_s;
            shift_r <= shift_s;
            addr_r  <= addr_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-register values for the transfer sequencer.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        wait_s  = wait_r;
        word_s  = word_r;
        shift_s = shift_r;
        addr_s  = addr_r;
        tx_s    = tx_r;
        busy_s  = busy_r;
        done_s  = 1'b0;

        case (state_r)
            S_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
                if (start) begin
                    addr_s  = '0;
                    wait_s  = '0;
                    word_s  = '0;
                    busy_s  = 1'b1;
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            // rd_data is trusted only once the RAM pipeline has caught up with rd_addr.
            S_FETCH: begin
                tx_s = 1'b1;
                if (wait_r == WAIT_LAST) begin
                    shift_s = rd_data;
                    baud_s  = '0;
                    tx_s    = 1'b0;
                    state_s = S_START;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            S_START: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = '0;
                    bit_s   = '0;
                    tx_s    = shift_r[0];
                    state_s = S_DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (bit_r == BIT_LAST) begin
                        tx_s    = 1'b1;
                        state_s = S_STOP;
                    end else begin
                        bit_s   = bit_r + BIT_W'(1);
                        shift_s = shift_r >> 1;
                        tx_s    = shift_s[0];
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            // The word counter is one bit wider than rd_addr so a full RAM never wraps early.
            S_STOP: begin
                tx_s = 1'b1;
                if (baud_r == BAUD_LAST) begin
                    baud_s = '0;
                    if (word_r == WORD_LAST) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = S_DONE;
                    end else begin
                        word_s  = word_r + WORD_W'(1);
                        addr_s  = addr_r + addr_bits'(1);
                        wait_s  = '0;
                        state_s = S_FETCH;
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            S_DONE: begin
                tx_s    = 1'b1;
                busy_s  = 1'b0;
                addr_s  = '0;
                word_s  = '0;
                state_s = S_IDLE;
            end
            default: begin
                tx_s    = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    assign rd_addr = addr_r;
    assign tx      = tx_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: table-driven frame decoding, a cycle-level line
// model, randomized RAM contents, reset/lockout corners and full baud timing.
module tb_result_uart_tx;

    localparam int GAP     = 3;     // read latency plus the latch edge
    localparam int NBITS   = 10;    // start + 8 data + stop
    localparam int LOG_MAX = 4400;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic start_a, start_c;

    logic [7:0] rd_addr_a, rd_data_a, aq_a;
    logic [1:0] rd_addr_b, aq_b;
    logic [7:0] rd_data_b;
    logic [7:0] rd_addr_c, rd_data_c, aq_c;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    logic [7:0] ram_a [0:255];
    logic [7:0] ram_b [0:3];
    logic [7:0] ram_c [0:255];

    result_uart_tx #(.CLKS_PER_BIT(4), .data_bits(8), .addr_bits(8), .NUM_WORDS(3), .RD_LATENCY(2))
    dut_a (.clk(clk), .rst(rst_a), .start(start_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
           .tx(tx_a), .busy(busy_a), .done(done_a));

    result_uart_tx #(.CLKS_PER_BIT(4), .data_bits(8), .addr_bits(2), .NUM_WORDS(4), .RD_LATENCY(2))
    dut_b (.clk(clk), .rst(rst_b), .start(1'b1), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
           .tx(tx_b), .busy(busy_b), .done(done_b));

    result_uart_tx #(.CLKS_PER_BIT(434), .data_bits(8), .addr_bits(8), .NUM_WORDS(1), .RD_LATENCY(2))
    dut_c (.clk(clk), .rst(rst_c), .start(start_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
           .tx(tx_c), .busy(busy_c), .done(done_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-stage RAM read pipeline: registered address, registered data.
    always @(posedge clk) begin
        aq_a <= rd_addr_a;
        rd_data_a <= ram_a[aq_a];
        aq_b <= rd_addr_b;
        rd_data_b <= ram_b[aq_b];
        aq_c <= rd_addr_c;
        rd_data_c <= ram_c[aq_c];
    end

    int n_checks, n_pass;
    logic tx_log [0:LOG_MAX-1];
    logic busy_log [0:LOG_MAX-1];
    logic done_log [0:LOG_MAX-1];
    int   addr_log [0:LOG_MAX-1];
    int   n_log;
    logic rs_tx, rs_busy, rs_done;
    int   rs_addr;

    logic [7:0] cur_words [0:3];
    int cur_n, cur_cpb;
    bit cur_repeat;

    typedef struct {
        int dut;
        int n;
        logic [3:0][7:0] w;
        logic [3:0][9:0] f;
    } vec_t;
    vec_t vecs [0:2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_vec(input int i, input int dut, input int n,
                           input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3,
                           input logic [9:0] f0, input logic [9:0] f1, input logic [9:0] f2, input logic [9:0] f3);
        vecs[i].dut = dut;
        vecs[i].n = n;
        vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
        vecs[i].f[0] = f0; vecs[i].f[1] = f1; vecs[i].f[2] = f2; vecs[i].f[3] = f3;
    endtask

    // Line model: k counts clocks after the start edge.
    function automatic logic exp_tx(input int k);
        int p, total, off, b, j, kk;
        p = NBITS * cur_cpb + GAP;
        total = cur_n * p;
        kk = cur_repeat ? (k % (total + 2)) : k;
        if (kk >= total) return 1'b1;
        j = kk / p;
        off = kk % p;
        if (off < GAP) return 1'b1;
        b = (off - GAP) / cur_cpb;
        if (b == 0) return 1'b0;
        if (b == NBITS - 1) return 1'b1;
        return cur_words[j][b-1];
    endfunction

    function automatic int phase_k(input int k);
        int total;
        total = cur_n * (NBITS * cur_cpb + GAP);
        return cur_repeat ? (k % (total + 2)) : k;
    endfunction

    task automatic check_log(input string tag, input int reps);
        int total, bad_tx, bad_done, bad_busy, first_bad, mism, first_fall;
        int act_q[$];
        int exp_q[$];
        total = cur_n * (NBITS * cur_cpb + GAP);
        bad_tx = 0; bad_done = 0; bad_busy = 0; first_bad = -1; first_fall = -1;
        for (int k = 0; k < n_log; k++) begin
            if (tx_log[k] !== exp_tx(k)) begin
                bad_tx++;
                if (first_bad < 0) first_bad = k;
            end
            if (done_log[k] !== (phase_k(k) == total)) bad_done++;
            if (busy_log[k] !== (phase_k(k) < total)) bad_busy++;
            if (first_fall < 0 && tx_log[k] === 1'b0) first_fall = k;
            if (act_q.size() == 0 || act_q[$] != addr_log[k]) act_q.push_back(addr_log[k]);
        end
        if (bad_tx != 0) $display("  %s: first tx difference at cycle %0d", tag, first_bad);
        chk({tag, "_tx_wave_bad_cycles"}, bad_tx, 0);
        chk({tag, "_done_bad_cycles"}, bad_done, 0);
        chk({tag, "_busy_bad_cycles"}, bad_busy, 0);
        chk({tag, "_first_start_bit_cycle"}, first_fall, GAP);
        for (int r = 0; r < reps; r++) begin
            for (int j = 0; j < cur_n; j++) begin
                if (exp_q.size() == 0 || exp_q[$] != j) exp_q.push_back(j);
            end
        end
        if (exp_q[$] != 0) exp_q.push_back(0);
        mism = 0;
        if (act_q.size() != exp_q.size()) begin
            mism = 1000 + act_q.size();
        end else begin
            for (int i = 0; i < exp_q.size(); i++) if (act_q[i] != exp_q[i]) mism++;
        end
        chk({tag, "_rd_addr_seq_bad"}, mism, 0);
    endtask

    task automatic check_frames(input string tag, input int vi);
        logic [9:0] got;
        int p;
        p = NBITS * cur_cpb + GAP;
        for (int j = 0; j < vecs[vi].n; j++) begin
            for (int b = 0; b < NBITS; b++) begin
                got[NBITS-1-b] = tx_log[j*p + GAP + b*cur_cpb + cur_cpb/2];
            end
            chk($sformatf("%s_frame%0d_bits", tag, j), {22'd0, got}, {22'd0, vecs[vi].f[j]});
        end
    endtask

    task automatic run_a(input int lock_k, input int rst_k, input int len);
        n_log = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == rst_k) begin
                rst_a = 1'b0;
                #1;
                rs_tx = tx_a; rs_busy = busy_a; rs_done = done_a; rs_addr = int'(rd_addr_a);
                break;
            end
            tx_log[k] = tx_a; busy_log[k] = busy_a; done_log[k] = done_a; addr_log[k] = int'(rd_addr_a);
            n_log = k + 1;
            start_a = (k == lock_k);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask

    task automatic run_b(input int len);
        n_log = 0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < len; k++) begin
            tx_log[k] = tx_b; busy_log[k] = busy_b; done_log[k] = done_b; addr_log[k] = int'(rd_addr_b);
            n_log = k + 1;
            @(negedge clk);
        end
        rst_b = 1'b0;
    endtask

    task automatic run_c(input int len);
        n_log = 0;
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int k = 0; k < len; k++) begin
            tx_log[k] = tx_c; busy_log[k] = busy_c; done_log[k] = done_c; addr_log[k] = int'(rd_addr_c);
            n_log = k + 1;
            @(negedge clk);
        end
    endtask

    task automatic set_words_a(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
        ram_a[0] = w0; ram_a[1] = w1; ram_a[2] = w2;
        cur_words[0] = w0; cur_words[1] = w1; cur_words[2] = w2; cur_words[3] = 8'h00;
        cur_n = 3; cur_cpb = 4; cur_repeat = 1'b0;
    endtask

    task automatic release_and_idle(input string tag);
        int viol;
        @(negedge clk);
        rst_a = 1'b1;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) viol++;
        end
        chk({tag, "_idle_after_reset_bad"}, viol, 0);
    endtask

    localparam int P_A = NBITS * 4 + GAP;
    localparam int TOTAL_A = 3 * P_A;

    initial begin
        int trans_cnt, bad_space, last_t, first_t, done_k;
        n_checks = 0; n_pass = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_c = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 8'h00;
            ram_c[i] = 8'h00;
        end
        for (int i = 0; i < 4; i++) ram_b[i] = 8'h00;

        set_vec(0, 0, 3, 8'hA5, 8'h3C, 8'hFF, 8'h00,
                10'b0101001011, 10'b0001111001, 10'b0111111111, 10'b0000000000);
        set_vec(1, 0, 3, 8'h00, 8'h01, 8'h80, 8'h00,
                10'b0000000001, 10'b0100000001, 10'b0000000011, 10'b0000000000);
        set_vec(2, 1, 4, 8'h00, 8'h01, 8'h80, 8'h7F,
                10'b0000000001, 10'b0100000001, 10'b0000000011, 10'b0111111101);

        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx_a}, 32'd1);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_done", {31'd0, done_a}, 32'd0);
        chk("reset_rd_addr", {24'd0, rd_addr_a}, 32'd0);
        rst_a = 1'b1;
        rst_c = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            if (vecs[i].dut == 0) begin
                set_words_a(vecs[i].w[0], vecs[i].w[1], vecs[i].w[2]);
                run_a(-1, -1, TOTAL_A + 6);
                check_log($sformatf("vec%0d", i), 1);
                check_frames($sformatf("vec%0d", i), i);
            end else begin
                for (int j = 0; j < 4; j++) begin
                    ram_b[j] = vecs[i].w[j];
                    cur_words[j] = vecs[i].w[j];
                end
                cur_n = 4; cur_cpb = 4; cur_repeat = 1'b1;
                run_b(2 * (4 * P_A + 2) + 4);
                check_log($sformatf("vec%0d_held", i), 2);
                check_frames($sformatf("vec%0d_held", i), i);
            end
            repeat (3) @(negedge clk);
        end

        set_words_a(8'hA5, 8'h3C, 8'hFF);
        run_a(P_A + 10, -1, TOTAL_A + 6);
        check_log("lockout", 1);

        run_a(-1, P_A + GAP + 1, TOTAL_A + 6);
        chk("async_rst_tx", {31'd0, rs_tx}, 32'd1);
        chk("async_rst_busy", {31'd0, rs_busy}, 32'd0);
        chk("async_rst_done", {31'd0, rs_done}, 32'd0);
        chk("async_rst_rd_addr", rs_addr, 32'd0);
        release_and_idle("rst_start_bit");

        run_a(-1, P_A + GAP + 5 * 4 + 1, TOTAL_A + 6);
        chk("midframe_rst_tx", {31'd0, rs_tx}, 32'd1);
        chk("midframe_rst_busy", {31'd0, rs_busy}, 32'd0);
        chk("midframe_rst_rd_addr", rs_addr, 32'd0);
        release_and_idle("midframe");
        run_a(-1, -1, TOTAL_A + 6);
        check_log("after_rst", 1);

        for (int r = 0; r < 4; r++) begin
            set_words_a(8'($urandom), 8'($urandom), 8'($urandom));
            run_a(-1, -1, TOTAL_A + 6);
            check_log($sformatf("rand%0d", r), 1);
        end

        ram_c[0] = 8'h55;
        cur_words[0] = 8'h55;
        cur_n = 1; cur_cpb = 434; cur_repeat = 1'b0;
        run_c(NBITS * 434 + GAP + 6);
        check_log("baud", 1);
        trans_cnt = 0; bad_space = 0; last_t = -1; first_t = -1; done_k = -1;
        for (int k = 1; k < n_log; k++) begin
            if (tx_log[k] !== tx_log[k-1]) begin
                if (first_t < 0) first_t = k;
                if (last_t >= 0 && (k - last_t) != 434) bad_space++;
                last_t = k;
                trans_cnt++;
            end
            if (done_log[k] === 1'b1 && done_k < 0) done_k = k;
        end
        chk("baud_transition_count", trans_cnt, 10);
        chk("baud_bad_spacing", bad_space, 0);
        chk("baud_frame_length", done_k - first_t, 4340);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
